// File: rtl/acu_pwl_coef_pipe.sv
// acu_pwl_coef_pipe: pipelined multi-lane piecewise-linear activation coefficient unit.
// Each lane's sample is mapped to a knot index. Slope and offset are read from runtime-loadable
// tables shared by all lanes. The slope table is mirrored around the midpoint.
// Optional feature macro: ACU_MAC_EN. When it is defined, the design adds a third stage that
// computes y = sat((x*slope >>> FRAC_SH) + offset) and drives it on out_act.
module acu_pwl_coef_pipe #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int SEG_BITS = 4,
  parameter int NCH      = 4
`ifdef ACU_MAC_EN
  ,
  parameter int FRAC_SH  = 6
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*COEF_W-1:0] out_slope,
  output logic [NCH*COEF_W-1:0] out_offset,
`ifdef ACU_MAC_EN
  output logic [NCH*DATA_W-1:0] out_act,
`endif
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [SEG_BITS-1:0]   cfg_addr,
  input  logic [COEF_W-1:0]     cfg_wdata
);
  localparam int NSLOPE = 1 << (SEG_BITS - 1);
  localparam int NOFFS  = 1 << SEG_BITS;

  logic [COEF_W-1:0]     slope_tab  [NSLOPE];
  logic [COEF_W-1:0]     offset_tab [NOFFS];

  logic                  s1_valid;
  logic                  s1_mode;
  logic [NCH*DATA_W-1:0] s1_data;
  logic                  s2_valid;
  logic [NCH*COEF_W-1:0] s2_slope;
  logic [NCH*COEF_W-1:0] s2_offset;
  logic [NCH*COEF_W-1:0] slope_rd;
  logic [NCH*COEF_W-1:0] offset_rd;
  logic                  s1_adv;
  logic                  s2_adv;

  // A stage may take a new beat when it is empty or when its contents move on downstream.
`ifdef ACU_MAC_EN
  logic                  s3_valid;
  logic                  s3_adv;
  logic [NCH*DATA_W-1:0] s2_data;
  logic [NCH*DATA_W-1:0] act_calc;

  assign s3_adv    = !s3_valid || out_ready;
  assign s2_adv    = !s2_valid || s3_adv;
  assign out_valid = s3_valid;
`else
  assign s2_adv     = !s2_valid || out_ready;
  assign out_valid  = s2_valid;
  assign out_slope  = s2_slope;
  assign out_offset = s2_offset;
`endif
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Coefficient tables: cleared by reset. A write lands at the edge, so same-cycle reads see old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOPE; i++) slope_tab[i] <= '0;
      for (int i = 0; i < NOFFS; i++)  offset_tab[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_sel) offset_tab[cfg_addr] <= cfg_wdata;
      else         slope_tab[cfg_addr[SEG_BITS-2:0]] <= cfg_wdata;
    end
  end

  // S1: capture the accepted beat (samples and knot mode).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_data  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_data <= in_data;
      end
    end
  end

  // Per-lane knot decode and table lookup, from the S1 registers.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    logic [DATA_W-1:0]   x;
    logic [SEG_BITS-1:0] knot;
    logic [SEG_BITS-2:0] sidx;

    assign x = s1_data[gi*DATA_W +: DATA_W];

    // Uniform knots use the top bits. Fine knots drop the sign-duplicate bit and saturate out-of-range samples.
    always_comb begin
      knot = x[DATA_W-1 -: SEG_BITS];
      if (s1_mode) begin
        if (x[DATA_W-1] ^ x[DATA_W-2]) knot = {x[DATA_W-1], {(SEG_BITS-1){x[DATA_W-2]}}};
        else                           knot = x[DATA_W-2 -: SEG_BITS];
      end
    end

    assign sidx = knot[SEG_BITS-1] ? ~knot[SEG_BITS-2:0] : knot[SEG_BITS-2:0];
    assign slope_rd[gi*COEF_W +: COEF_W]  = slope_tab[sidx];
    assign offset_rd[gi*COEF_W +: COEF_W] = offset_tab[knot];
  end

  // S2: sample the coefficients once, on the S1->S2 transfer. A stalled beat keeps its values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_slope  <= '0;
      s2_offset <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_slope  <= slope_rd;
        s2_offset <= offset_rd;
      end
    end
  end

`ifdef ACU_MAC_EN
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int YW = PW + 1;

  // S2 also carries the samples forward for the multiply.
  always_ff @(posedge clk) begin
    if (!rst_n)                   s2_data <= '0;
    else if (s2_adv && s1_valid) s2_data <= s1_data;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_mac
    logic        [DATA_W-1:0] x;
    logic        [COEF_W-1:0] sl;
    logic        [COEF_W-1:0] of;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_sh;
    logic signed [YW-1:0]     y;
    logic        [DATA_W-YW:0] unused_pad;

    assign x  = s2_data[gi*DATA_W +: DATA_W];
    assign sl = s2_slope[gi*COEF_W +: COEF_W];
    assign of = s2_offset[gi*COEF_W +: COEF_W];
    // The slope is treated as unsigned magnitude. The sample and offset are signed.
    assign prod    = PW'($signed(x)) * PW'($signed({1'b0, sl}));
    assign prod_sh = prod >>> FRAC_SH;
    assign y       = YW'(prod_sh) + YW'($signed(of));
    // In range only when every bit above the result sign matches it. Otherwise clamp to the rail.
    assign act_calc[gi*DATA_W +: DATA_W] =
      (&y[YW-1:DATA_W-1] || ~|y[YW-1:DATA_W-1]) ? y[DATA_W-1:0] :
      (y[YW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
  end

  // S3: activation result, with the coefficients delayed alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid   <= 1'b0;
      out_slope  <= '0;
      out_offset <= '0;
      out_act    <= '0;
    end else if (s3_adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        out_slope  <= s2_slope;
        out_offset <= s2_offset;
        out_act    <= act_calc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_acu_pwl_coef_pipe.sv
// Scoreboard bench for acu_pwl_coef_pipe. The driver pushes the expected coefficients when a beat is accepted.
// A negedge monitor pops the queue and compares each beat the DUT presents. It also checks in_ready and stall stability.
`timescale 1ns/1ps
module tb_acu_pwl_coef_pipe;
  localparam int NCH = 4;
`ifdef ACU_MAC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_slope;
  logic [31:0] out_offset;
`ifdef ACU_MAC_EN
  logic [31:0] out_act;
`endif

  always #5 clk = ~clk;

  acu_pwl_coef_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_slope(out_slope),
    .out_offset(out_offset),
`ifdef ACU_MAC_EN
    .out_act(out_act),
`endif
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  typedef struct {
    logic [31:0] sl;
    logic [31:0] of;
    logic [31:0] act;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         failed = 0;
  int         acc_cnt = 0;
  int         con_cnt = 0;
  int         or_mode = 0;
  int         or_cnt = 0;
  logic [7:0] slope_m [8];
  logic [7:0] offset_m [16];
  logic [7:0] sl_init [8]  = '{8'h3E, 8'h37, 8'h2C, 8'h20, 8'h16, 8'h0E, 8'h09, 8'h05};
  logic [7:0] of_init [16] = '{8'h80, 8'h9F, 8'hBB, 8'hD1, 8'hE1, 8'hEC, 8'hF3, 8'hF8,
                               8'h04, 8'h07, 8'h0C, 8'h13, 8'h1E, 8'h2E, 8'h44, 8'h60};

  // Reference knot: the segment number from the sample value itself.
  function automatic int knot_of(input logic m, input logic [7:0] x);
    int sx;
    sx = int'($signed(x));
    if (!m) return int'(x) / 16;
    if (sx >= 64) return 7;
    if (sx < -64) return 8;
    return (int'(x) / 8) % 16;
  endfunction

  function automatic void model_exp(input logic m, input logic [31:0] d,
                                    output logic [31:0] sl, output logic [31:0] of);
    for (int i = 0; i < NCH; i++) begin
      int k;
      int si;
      k  = knot_of(m, d[i*8 +: 8]);
      si = (k < 8) ? k : 15 - k;
      sl[i*8 +: 8] = slope_m[si];
      of[i*8 +: 8] = offset_m[k];
    end
  endfunction

`ifdef ACU_MAC_EN
  function automatic logic [7:0] act_of(input logic [7:0] x, input logic [7:0] s, input logic [7:0] o);
    int p;
    int y;
    p = int'($signed(x)) * int'(s);
    p = p >>> 6;
    y = p + int'($signed(o));
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Call at posedge+1. Holds the beat until accepted and pushes its expectation at the accepting edge.
  task automatic send(input logic m, input logic [31:0] d, input logic [31:0] esl, input logic [31:0] eof);
    exp_t e;
    int   n;
    bit   done;
    e.sl = esl;
    e.of = eof;
    e.act = '0;
`ifdef ACU_MAC_EN
    for (int i = 0; i < NCH; i++) e.act[i*8 +: 8] = act_of(d[i*8 +: 8], esl[i*8 +: 8], eof[i*8 +: 8]);
`endif
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (done) acc_cnt++;
      n++;
      if (!done && n > 200) begin
        tests++;
        failed++;
        $display("FAIL send_timeout: beat not accepted in 200 cycles, required acceptance");
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic m, input logic [31:0] d);
    logic [31:0] sl;
    logic [31:0] of;
    model_exp(m, d, sl, of);
    send(m, d, sl, of);
  endtask

  task automatic cfg_write(input logic sel, input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (sel) offset_m[a] = d;
    else     slope_m[a[2:0]] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || acc_cnt != con_cnt) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      tests++;
      failed++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", sb.size());
    end
  endtask

  // out_ready pattern generator: 0 always on, 1 = 1,0,0 repeating, 2 random, 3 held off.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (or_cnt % 3 == 0); or_cnt++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake, stall stability and scoreboard comparison.
  initial begin
    logic        stall_q;
    logic [31:0] stall_sl;
    logic [31:0] stall_of;
    exp_t        e;
    bit          ir_req;
    stall_q = 0;
    stall_sl = '0;
    stall_of = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall_q = 0;
        continue;
      end
      ir_req = !((acc_cnt - con_cnt) == DEPTH && !out_ready);
      tests++;
      if (in_ready !== ir_req) begin
        failed++;
        $display("FAIL in_ready: got %b required %b (in flight %0d, out_ready %b)",
                 in_ready, ir_req, acc_cnt - con_cnt, out_ready);
      end
      if (stall_q) begin
        tests++;
        if (out_valid !== 1'b1 || out_slope !== stall_sl || out_offset !== stall_of) begin
          failed++;
          $display("FAIL stall_hold: got v=%b %h/%h required v=1 %h/%h",
                   out_valid, out_slope, out_offset, stall_sl, stall_of);
        end
      end
      stall_q  = (out_valid === 1'b1) && !out_ready;
      stall_sl = out_slope;
      stall_of = out_offset;
      if (out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_beat: got slope %h offset %h, required no beat", out_slope, out_offset);
        end else begin
          e = sb.pop_front();
          $display("[TB] beat %0d slope %h offset %h", con_cnt, out_slope, out_offset);
          check("beat_slope", out_slope, e.sl);
          check("beat_offset", out_offset, e.of);
`ifdef ACU_MAC_EN
          check("beat_act", out_act, e.act);
`endif
        end
        con_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sl;
    logic [31:0] of;
    for (int i = 0; i < 8; i++)  slope_m[i] = '0;
    for (int i = 0; i < 16; i++) offset_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_slope", out_slope, 32'd0);
    check("reset_out_offset", out_offset, 32'd0);
    @(posedge clk);
    #1;

    // Load the reference tables.
    for (int i = 0; i < 8; i++)  cfg_write(1'b0, 4'(i), sl_init[i]);
    for (int i = 0; i < 16; i++) cfg_write(1'b1, 4'(i), of_init[i]);

    // Uniform knots, with a latency check.
    send(1'b0, 32'hF0953505, 32'h3E09203E, 32'h6007D180);
    for (int k = 1; k < DEPTH; k++) begin
      @(negedge clk);
      check("latency_early", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_idle();

    // Fine knots, including both saturated end segments.
    send(1'b1, 32'h00288848, 32'h3E0E0505, 32'h80EC04F8);
    wait_idle();

    // Backpressure with a counting pattern.
    or_cnt = 0;
    or_mode = 1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] d;
      for (int i = 0; i < NCH; i++) d[i*8 +: 8] = 8'((4 * k + i) * 8);
      send_model(1'(k % 2), d);
    end
    wait_idle();
    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Offset write lands on the same edge that a knot-0 beat leaves S1.
    send_model(1'b0, 32'h05030201);
    offset_m[0] = 8'hAA;
    cfg_we = 1'b1;
    cfg_sel = 1'b1;
    cfg_addr = 4'd0;
    cfg_wdata = 8'hAA;
    model_exp(1'b0, 32'h05030201, sl, of);
    send(1'b0, 32'h05030201, sl, of);
    cfg_we = 1'b0;
    wait_idle();

    // Reset with two beats in flight.
    or_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    send_model(1'b0, 32'h11223344);
    send_model(1'b1, 32'h55667788);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    acc_cnt = 0;
    con_cnt = 0;
    for (int i = 0; i < 8; i++)  slope_m[i] = '0;
    for (int i = 0; i < 16; i++) offset_m[i] = '0;
    @(negedge clk);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 32'h12F4A678, 32'd0, 32'd0);
    wait_idle();

`ifdef ACU_MAC_EN
    // Activation path: nominal result and positive saturation.
    cfg_write(1'b0, 4'd2, 8'h40);
    cfg_write(1'b1, 4'd2, 8'h10);
    cfg_write(1'b0, 4'd7, 8'hFF);
    cfg_write(1'b1, 4'd7, 8'h7F);
    send_model(1'b0, 32'h20202020);
    send_model(1'b0, 32'h7F7F7F7F);
    wait_idle();
`endif

    // Randomized streams with random backpressure. Table writes happen between bursts.
    for (int i = 0; i < 8; i++)  cfg_write(1'b0, 4'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) cfg_write(1'b1, 4'(i), 8'($urandom));
    or_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 20; k++) begin
        send_model(1'($urandom_range(0, 1)), $urandom);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle();
      cfg_write(1'b0, 4'($urandom_range(0, 7)), 8'($urandom));
      cfg_write(1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
    end
    or_mode = 0;
    wait_idle();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
